// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: default geometry and elaboration helpers for the pipelined adder.
package pipe_add_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  function automatic int chunk_w(input int w, input int s);
    return w / s;
  endfunction
  function automatic bit width_ok(input int w, input int s);
    return s >= 1 && s <= w && (w % s) == 0;
  endfunction
endpackage

// File: rtl/pipe_add_slice.sv
// pipe_add_slice: combinational ripple-carry slice; also exposes the carry into its MSB.
module pipe_add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout,
  output logic         o_cmsb
);
  logic [W:0] w_c;
  always_comb begin
    w_c[0] = i_cin;
    for (int i = 0; i < W; i++) w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_s = i_a ^ i_b ^ w_c[W-1:0];
  assign o_cout = w_c[W];
  assign o_cmsb = w_c[W-1];
endmodule

// File: rtl/pipe_add.sv
// pipe_add: pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Define PIPE_ADD_OVF_EN to add the out_ovf signed-overflow output.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef PIPE_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  assign w_b_eff = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub | in_cin;
  if (!width_ok(WIDTH, STAGES)) begin : g_bad
    $fatal(1, "pipe_add: WIDTH must be a multiple of STAGES");
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits still waiting to be added when entering stage k.
    localparam int PW = WIDTH - k * CHUNK;
    logic [PW-1:0]          w_pa, w_pb;
    logic                   w_pc, w_pv, w_ld, w_co, w_cm;
    logic [CHUNK-1:0]       w_s;
    logic [(k+1)*CHUNK-1:0] w_sn;
    logic                   r_v, r_c;
    logic [(k+1)*CHUNK-1:0] r_s;
    if (k == 0) begin : g_src
      assign w_pa = in_a;
      assign w_pb = w_b_eff;
      assign w_pc = w_cin_eff;
      assign w_pv = in_valid;
      assign w_sn = w_s;
    end else begin : g_src
      assign w_pa = g_st[k-1].g_pend.r_a;
      assign w_pb = g_st[k-1].g_pend.r_b;
      assign w_pc = g_st[k-1].r_c;
      assign w_pv = g_st[k-1].r_v;
      assign w_sn = {w_s, g_st[k-1].r_s};
    end
    if (k == STAGES - 1) begin : g_rdy
      assign w_ld = !r_v || out_ready;
    end else begin : g_rdy
      assign w_ld = !r_v || g_st[k+1].w_ld;
    end
    pipe_add_slice #(.W(CHUNK)) u_slice (
      .i_a(w_pa[CHUNK-1:0]),
      .i_b(w_pb[CHUNK-1:0]),
      .i_cin(w_pc),
      .o_s(w_s),
      .o_cout(w_co),
      .o_cmsb(w_cm)
    );
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_ld) begin
        r_v <= w_pv;
        r_c <= w_co;
        r_s <= w_sn;
      end
    end
    if (k < STAGES - 1) begin : g_pend
      logic [PW-CHUNK-1:0] r_a, r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ld) begin
          r_a <= w_pa[PW-1:CHUNK];
          r_b <= w_pb[PW-1:CHUNK];
        end
      end
    end
`ifdef PIPE_ADD_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic r_ovf;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ovf <= 1'b0;
        else if (w_ld) r_ovf <= w_cm ^ w_co;
      end
    end else begin : g_ovf
      logic w_unused;
      assign w_unused = w_cm;
    end
`else
    logic w_unused;
    assign w_unused = w_cm;
`endif
  end
  assign in_ready = g_st[0].w_ld;
  assign out_valid = g_st[STAGES-1].r_v;
  assign out_sum = g_st[STAGES-1].r_s;
  assign out_cout = g_st[STAGES-1].r_c;
`ifdef PIPE_ADD_OVF_EN
  assign out_ovf = g_st[STAGES-1].g_ovf.r_ovf;
`endif
endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: randomized scoreboard bench for pipe_add against an arithmetic reference model.
module tb_pipe_add;
  localparam int W = 16;
  localparam int S = 4;
`ifdef PIPE_ADD_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_cin = 0, in_sub = 0, out_ready = 1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_cout;
  logic [W-1:0] out_sum;
`ifdef PIPE_ADD_OVF_EN
  logic out_ovf;
`endif
  int n_chk = 0, n_err = 0, cyc = 0, acc = 0, acc0 = 0;
  logic [17:0] q[$];
  int tq[$];
  logic [17:0] cur_exp = '0, stall_val = '0;
  bit lat_chk = 1, stall_prev = 0;

  pipe_add #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef PIPE_ADD_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] r;
    logic ovf;
    be = sub ? ~b : b;
    r = a + be + (sub ? 17'd1 : {16'd0, cin});
    ovf = OVF && (a[15] == be[15]) && (r[15] != a[15]);
    return {ovf, r};
  endfunction

  function automatic logic [17:0] got_val();
`ifdef PIPE_ADD_OVF_EN
    return {out_ovf, out_cout, out_sum};
`else
    return {1'b0, out_cout, out_sum};
`endif
  endfunction

  task automatic tick();
    int t;
    @(negedge clk);
    if (in_valid && in_ready) begin
      q.push_back(cur_exp);
      tq.push_back(cyc);
      acc++;
    end
    if (stall_prev && out_valid) check("stable", got_val(), stall_val);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious", 1, 0);
      else begin
        check("result", got_val(), q.pop_front());
        t = tq.pop_front();
        if (lat_chk) check("latency", cyc - t, S);
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_val = got_val();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub, input logic [17:0] e);
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    cur_exp = e;
    tick();
  endtask

  task automatic rnd_beat();
    logic [15:0] a, b;
    logic c, s;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 1'($urandom);
    s = 1'($urandom);
    beat(a, b, c, s, model(a, b, c, s));
  endtask

  task automatic idle();
    in_valid = 0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) idle();
    check("drain", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef PIPE_ADD_OVF_EN
    check("rst_out_ovf", out_ovf, 0);
`endif
    rst_n = 1;
    @(posedge clk);
    #1;
    beat(16'hFFFF, 16'h0001, 0, 0, {1'b0, 1'b1, 16'h0000});
    beat(16'h0005, 16'h0007, 1, 1, {1'b0, 1'b0, 16'hFFFE});
    beat(16'h0007, 16'h0005, 1, 1, {1'b0, 1'b1, 16'h0002});
    beat(16'h7FFF, 16'h0001, 0, 0, {OVF, 1'b0, 16'h8000});
    beat(16'h1234, 16'h0F0F, 1, 0, {1'b0, 1'b0, 16'h2144});
    drain();
    check("directed_accepted", acc, 5);
    acc0 = acc;
    repeat (100) rnd_beat();
    drain();
    check("b2b_accepted", acc - acc0, 100);
    lat_chk = 0;
    out_ready = 0;
    acc0 = acc;
    repeat (10) rnd_beat();
    check("bp_accepted", acc - acc0, S);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1;
    drain();
    repeat (200) begin
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) == 1) rnd_beat();
      else idle();
    end
    out_ready = 1;
    drain();
    lat_chk = 1;
    repeat (3) rnd_beat();
    in_valid = 0;
    rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    q.delete();
    tq.delete();
    stall_prev = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc++;
    beat(16'h0100, 16'h0200, 0, 0, {1'b0, 1'b0, 16'h0300});
    drain();
    repeat (8) idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
